// File: rtl/cdc_pkg.sv
// Shared helpers for the dual-clock FIFO pointer controllers.
// Provides Gray encoding and the synchronizer depth floor.
package cdc_pkg;

    localparam int CDC_MIN_SYNC_STAGES = 2;

    function automatic logic [31:0] bin2gray(input logic [31:0] b);
        return b ^ (b >> 1);
    endfunction

endpackage

// File: rtl/cdc_sync_bus.sv
// Multi-flop synchronizer for a Gray-coded bus.
// Plain flop chain, no logic between stages.
module cdc_sync_bus #(
    parameter int WIDTH  = 4,
    parameter int STAGES = 2
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic [WIDTH-1:0] d_i,
    output logic [WIDTH-1:0] q_o
);

    logic [WIDTH-1:0] stage_q [STAGES];
    logic [WIDTH-1:0] stage_d [STAGES];

    // each stage takes the previous one
    always_comb begin
        stage_d[0] = d_i;
        for (int i = 1; i < STAGES; i++) begin
            stage_d[i] = stage_q[i-1];
        end
    end

    // chain of flops, cleared by reset
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            for (int i = 0; i < STAGES; i++) begin
                stage_q[i] <= '0;
            end
        end else begin
            for (int i = 0; i < STAGES; i++) begin
                stage_q[i] <= stage_d[i];
            end
        end
    end

    assign q_o = stage_q[STAGES-1];

endmodule

// File: rtl/gray2bin.sv
// Gray to binary converter, width set by WIDTH.
// Each binary bit is the XOR of all Gray bits at or above it.
module gray2bin #(
    parameter int WIDTH = 4
) (
    input  logic [WIDTH-1:0] gray_i,
    output logic [WIDTH-1:0] bin_o
);

    // prefix XOR from the MSB down
    always_comb begin
        bin_o = '0;
        for (int i = 0; i < WIDTH; i++) begin
            bin_o[i] = ^(gray_i >> i);
        end
    end

endmodule

// File: rtl/cdc_fifo_rd_ctrl.sv
// Read-side pointer/status controller for the dual-clock FIFO.
// Define CDC_FIFO_RD_LEVEL_EN to build the fill-level output.
module cdc_fifo_rd_ctrl
    import cdc_pkg::*;
#(
    parameter int ADDR_WIDTH  = 3,
    parameter int SYNC_STAGES = 2
) (
    input  logic                  clk_i,
    input  logic                  rst_ni,
    input  logic [ADDR_WIDTH:0]   wr_ptr_gray_i,
    input  logic                  rd_en_i,
    output logic [ADDR_WIDTH-1:0] rd_addr_o,
    output logic [ADDR_WIDTH:0]   rd_ptr_gray_o,
    output logic                  empty_o,
    output logic [ADDR_WIDTH:0]   level_o,
    output logic                  underflow_o
);

    localparam int PW = ADDR_WIDTH + 1;

    if (SYNC_STAGES < CDC_MIN_SYNC_STAGES) begin : g_bad_sync
        $error("cdc_fifo_rd_ctrl: SYNC_STAGES below minimum");
    end

    logic [PW-1:0] wr_gray_sync;
    logic [PW-1:0] rd_bin_q, rd_bin_d;
    logic [PW-1:0] rd_gray_q, rd_gray_d;
    logic [PW-1:0] level_q, level_d;
    logic          empty_q, empty_d;
    logic          underflow_q, underflow_d;
    logic          rd_acc;

    cdc_sync_bus #(
        .WIDTH  (PW),
        .STAGES (SYNC_STAGES)
    ) u_wr_sync (
        .clk_i  (clk_i),
        .rst_ni (rst_ni),
        .d_i    (wr_ptr_gray_i),
        .q_o    (wr_gray_sync)
    );

`ifdef CDC_FIFO_RD_LEVEL_EN
    logic [PW-1:0] wr_bin_sync;

    gray2bin #(
        .WIDTH (PW)
    ) u_wr_g2b (
        .gray_i (wr_gray_sync),
        .bin_o  (wr_bin_sync)
    );
`endif

    // advance pointer on accepted read; status from post-increment pointer
    always_comb begin
        rd_acc      = rd_en_i & ~empty_q;
        rd_bin_d    = rd_bin_q + PW'(rd_acc);
        rd_gray_d   = PW'(bin2gray(32'(rd_bin_d)));
        empty_d     = (rd_gray_d == wr_gray_sync);
        underflow_d = rd_en_i & empty_q;
`ifdef CDC_FIFO_RD_LEVEL_EN
        level_d     = wr_bin_sync - rd_bin_d;
`else
        level_d     = '0;
`endif
    end

    // state and status registers
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            rd_bin_q    <= '0;
            rd_gray_q   <= '0;
            empty_q     <= 1'b1;
            level_q     <= '0;
            underflow_q <= 1'b0;
        end else begin
            rd_bin_q    <= rd_bin_d;
            rd_gray_q   <= rd_gray_d;
            empty_q     <= empty_d;
            level_q     <= level_d;
            underflow_q <= underflow_d;
        end
    end

    assign rd_addr_o     = rd_bin_q[ADDR_WIDTH-1:0];
    assign rd_ptr_gray_o = rd_gray_q;
    assign empty_o       = empty_q;
    assign level_o       = level_q;
    assign underflow_o   = underflow_q;

endmodule

// File: doc/cdc_fifo_rd_ctrl.md
# cdc_fifo_rd_ctrl

Read-domain pointer and status controller for the dual-clock FIFO. It synchronizes the Gray-coded write pointer into the read clock domain and converts it to binary with the existing `gray2bin` block. It maintains the read pointer in binary and Gray form, and produces registered empty, fill-level and underflow status for the read-side consumer. It sits between the FIFO storage array (addressed by `rd_addr_o`) and the write-domain controller, which consumes `rd_ptr_gray_o`.

## Interface
- Clock is `clk_i`; reset is `rst_ni`. There is one clock; reset is asynchronous and active-low.

Parameters:
- `ADDR_WIDTH`, default 3: FIFO depth is 2^ADDR_WIDTH. Pointers are ADDR_WIDTH+1 bits wide.
- `SYNC_STAGES`, default 2: number of flops in the write-pointer synchronizer, minimum 2.

Ports:
- `clk_i` input 1: read-domain clock.
- `rst_ni` input 1: asynchronous active-low reset.
- `wr_ptr_gray_i` input ADDR_WIDTH+1: Gray write pointer, asynchronous to `clk_i`.
- `rd_en_i` input 1: read request.
- `rd_addr_o` output ADDR_WIDTH: storage read address, equal to the low bits of the binary read pointer.
- `rd_ptr_gray_o` output ADDR_WIDTH+1: registered Gray read pointer, sent to the write domain.
- `empty_o` output 1: registered; high when the FIFO holds no entries.
- `level_o` output ADDR_WIDTH+1: registered fill level, 0 to 2^ADDR_WIDTH.
- `underflow_o` output 1: single-cycle pulse on a rejected read.

## Operation
- Synchronizer: `wr_ptr_gray_i` passes through SYNC_STAGES flops. Its output is `wr_gray_sync`.
- Read acceptance: `rd_acc = rd_en_i & ~empty_o`.
- On `rd_acc`, the binary read pointer increments. It wraps modulo 2^(ADDR_WIDTH+1): all-ones returns to 0, and no saturation is applied.
- Next-state values are computed from the post-increment read pointer `rd_bin_next`:
  - `rd_ptr_gray_o` ← bin2gray(`rd_bin_next`).
  - `empty_o` ← (bin2gray(`rd_bin_next`) == `wr_gray_sync`), a full-width compare including the MSB.
- `rd_en_i & empty_o` asserts `underflow_o` for one cycle. The pointer stays unchanged and no other state changes.
- Simultaneous events: a read accept and a change of `wr_gray_sync` in the same cycle are both folded into the same next-state computation. Neither is dropped.
- Reset values, applied asynchronously:
  - Read pointer (binary and Gray) = 0.
  - `rd_addr_o` = 0, `rd_ptr_gray_o` = 0.
  - All synchronizer flops = 0.
  - `empty_o` = 1, `level_o` = 0, `underflow_o` = 0.
- Reset asserted mid-operation: every output returns to its reset value immediately, with no clock needed. On release, the synchronizer refills, and `empty_o` stays 1 until a nonzero write pointer has propagated through it.
- Behaviour is undefined if `wr_ptr_gray_i` changes by more than one Gray step per write edge. That condition is the write controller's responsibility.

## Timing
- Read latency: `rd_addr_o` and `rd_ptr_gray_o` update on the first rising edge after the cycle in which `rd_acc` is high. `empty_o` and `level_o` update on the same edge.
- Write-to-status latency: a change on `wr_ptr_gray_i` that is stable before edge 1 is reflected in `empty_o`/`level_o` after edge SYNC_STAGES+1. For the default SYNC_STAGES=2, that is edge 3.
- `underflow_o` is registered: it is high for the one cycle after the rejected request.
- There are no combinational paths from inputs to outputs.

## Configuration
- Macro: `CDC_FIFO_RD_LEVEL_EN`.
- Defined:
  - `gray2bin` converts `wr_gray_sync` to `wr_bin_sync`.
  - `level_o` ← (`wr_bin_sync` − `rd_bin_next`) mod 2^(ADDR_WIDTH+1), registered.
- Undefined:
  - No `gray2bin` instance and no subtractor.
  - `level_o` is tied to 0.
  - Empty detection remains the Gray compare, so `empty_o` behaviour is identical in both builds.

## Structure
- `cdc_pkg` holds the function `bin2gray` (parameterized width via a let or automatic function) and the constant `CDC_MIN_SYNC_STAGES` = 2.
- Synchronizer sub-module: `cdc_sync_bus` (WIDTH, STAGES). It is a plain flop chain with the same asynchronous active-low reset, with no logic between stages.
- `gray2bin` is instantiated unchanged, only under `CDC_FIFO_RD_LEVEL_EN`.
- A parameter check rejects `SYNC_STAGES < CDC_MIN_SYNC_STAGES`.

## Test plan
All scenarios use ADDR_WIDTH=3, SYNC_STAGES=2, and a build with `CDC_FIFO_RD_LEVEL_EN` defined.
1. Reset: hold `rst_ni`=0 with `clk_i` stopped → `empty_o`=1, `level_o`=0, `rd_ptr_gray_o`=4'b0000, `rd_addr_o`=0, `underflow_o`=0.
2. Single write: drive `wr_ptr_gray_i` from 4'b0000 to 4'b0001 before edge 1 → `empty_o`=0 and `level_o`=1 after edge 3, and not before.
3. Single read: from scenario 2, assert `rd_en_i` for 1 cycle → next edge gives `rd_addr_o`=1, `rd_ptr_gray_o`=4'b0001, `empty_o`=1, `level_o`=0.
4. Underflow: with `empty_o`=1, assert `rd_en_i` for 2 cycles → `underflow_o` high for 2 cycles; `rd_addr_o` and `rd_ptr_gray_o` unchanged.
5. Full and wrap:
   - Step `wr_ptr_gray_i` to binary 8 (4'b1100) → `level_o`=8.
   - Read 8 entries → `rd_ptr_gray_o`=4'b1100 and `empty_o`=1.
   - Repeat with the pointer crossing 15 (4'b1000) to 0 → `rd_addr_o` sequence 7,0 and `level_o` correct across the wrap.
6. Reset mid-read: with `level_o`=5 and `rd_en_i` high, pulse `rd_ni` low between edges → outputs at reset values immediately; after release with `wr_ptr_gray_i` held nonzero, `empty_o` stays 1 for 2 edges and then deasserts.
